// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation codes, data width and default busy-cycle counts.
package mdu_defs;

  localparam int DATA_W = 32;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MFHI  = 4'd5;
  localparam md_op_t MD_MFLO  = 4'd6;
  localparam md_op_t MD_MTHI  = 4'd7;
  localparam md_op_t MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle; master is the pipeline side,
// slave is the multiply/divide controller.
interface mdu_ctrl_if;
  import mdu_defs::*;

  md_op_t              md_op;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   rt_val;
  logic                d_is_md;
  logic                start;
  logic                busy;
  logic                stall_md;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;
  logic [DATA_W-1:0]   md_rdata;

  modport master (
    output md_op, rs_val, rt_val, d_is_md,
    input  start, busy, stall_md, hi_o, lo_o, md_rdata
  );

  modport slave (
    input  md_op, rs_val, rt_val, d_is_md,
    output start, busy, stall_md, hi_o, lo_o, md_rdata
  );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide result generator; the controller latches
// its outputs at accept and commits them when the busy period expires.
module mdu_arith
  import mdu_defs::*;
(
  input  md_op_t             op,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  output logic [DATA_W-1:0]  pending_hi,
  output logic [DATA_W-1:0]  pending_lo,
  output logic               div_by_zero
);

  logic signed [2*DATA_W-1:0] rs_x, rt_x, prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic signed [DATA_W-1:0]   rs_s, rt_safe_s, quot_s, rem_s;
  logic        [DATA_W-1:0]   rt_safe_u, quot_u, rem_u;
  logic                       div_ovf;

  assign rs_x   = {{DATA_W{rs[DATA_W-1]}}, rs};
  assign rt_x   = {{DATA_W{rt[DATA_W-1]}}, rt};
  assign prod_s = rs_x * rt_x;
  assign prod_u = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};

  // Dividing the most negative value by -1 through a divisor of 1 yields
  // exactly the architectural result (LO = 0x80000000, HI = 0) without overflow.
  assign div_ovf   = (rs == {1'b1, {(DATA_W-1){1'b0}}}) && (rt == {DATA_W{1'b1}});
  assign rs_s      = rs;
  assign rt_safe_s = ((rt == '0) || div_ovf) ? DATA_W'(1) : rt;
  assign rt_safe_u = (rt == '0) ? DATA_W'(1) : rt;
  assign quot_s    = rs_s / rt_safe_s;
  assign rem_s     = rs_s % rt_safe_s;
  assign quot_u    = rs / rt_safe_u;
  assign rem_u     = rs % rt_safe_u;

  assign div_by_zero = is_div_op(op) && (rt == '0);

  always_comb begin
    pending_hi = '0;
    pending_lo = '0;
    case (op)
      MD_MULT:  {pending_hi, pending_lo} = prod_s;
      MD_MULTU: {pending_hi, pending_lo} = prod_u;
      MD_DIV: begin
        pending_hi = rem_s;
        pending_lo = quot_s;
      end
      MD_DIVU: begin
        pending_hi = rem_u;
        pending_lo = quot_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: busy countdown, HI/LO ownership and
// the stall request used to hold D-stage multiply/divide instructions.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0]  cnt_p1;
  logic              busy_p1;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] pend_hi_p1, pend_lo_p1;
  logic              pend_dz_p1;

  logic [DATA_W-1:0] arith_hi, arith_lo;
  logic              arith_dz;

  mdu_arith u_arith (
    .op          (md.md_op),
    .rs          (md.rs_val),
    .rt          (md.rt_val),
    .pending_hi  (arith_hi),
    .pending_lo  (arith_lo),
    .div_by_zero (arith_dz)
  );

  assign md.start    = is_start_op(md.md_op);
  assign md.busy     = busy_p1;
  assign md.stall_md = md.d_is_md & (md.start | busy_p1);
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;

  always_comb begin
    md.md_rdata = '0;
    if (md.md_op == MD_MFHI)      md.md_rdata = hi_q;
    else if (md.md_op == MD_MFLO) md.md_rdata = lo_q;
  end

  // Accept stage: ops are only taken while idle; anything issued during busy is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1     <= '0;
      busy_p1    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_p1 <= '0;
      pend_lo_p1 <= '0;
      pend_dz_p1 <= 1'b0;
    end else if (busy_p1) begin
      if (cnt_p1 == CNT_W'(1)) begin
        if (!pend_dz_p1) begin
          hi_q <= pend_hi_p1;
          lo_q <= pend_lo_p1;
        end
        busy_p1 <= 1'b0;
        cnt_p1  <= '0;
      end else begin
        cnt_p1 <= cnt_p1 - CNT_W'(1);
      end
    end else begin
      case (md.md_op)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          cnt_p1     <= is_div_op(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          busy_p1    <= 1'b1;
          pend_hi_p1 <= arith_hi;
          pend_lo_p1 <= arith_lo;
          pend_dz_p1 <= arith_dz;
        end
        MD_MTHI: hi_q <= md.rs_val;
        MD_MTLO: lo_q <= md.rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_mdu_ctrl;
  import mdu_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic        busy;
    logic        start;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural model: HI/LO, remaining busy cycles, pending result.
  int          m_left  = 0;
  logic [31:0] m_hi    = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  bit          m_pdz   = 0;
  bit          m_known = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_edge(input logic rst_i, input md_op_t op,
                            input logic [31:0] rs, input logic [31:0] rt);
    int sa, sb;
    longint p, q, r;
    longint unsigned ua, ub, pu;
    sa = rs; sb = rt; ua = rs; ub = rt;
    if (rst_i) begin
      if (m_left > 0) void'(len_q.pop_back());
      m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pdz = 0;
      m_known = 1;
    end else if (m_left > 0) begin
      if (m_left == 1 && !m_pdz) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
      m_left--;
    end else begin
      case (op)
        MD_MULT: begin
          p = longint'(sa) * longint'(sb);
          {m_phi, m_plo} = p; m_pdz = 0; m_left = MC;
        end
        MD_MULTU: begin
          pu = ua * ub;
          {m_phi, m_plo} = pu; m_pdz = 0; m_left = MC;
        end
        MD_DIV: begin
          m_pdz = (sb == 0);
          if (sb != 0) begin
            q = longint'(sa) / longint'(sb);
            r = longint'(sa) % longint'(sb);
            m_plo = q[31:0]; m_phi = r[31:0];
          end
          m_left = DC;
        end
        MD_DIVU: begin
          m_pdz = (ub == 0);
          if (ub != 0) begin
            m_plo = 32'(ua / ub); m_phi = 32'(ua % ub);
          end
          m_left = DC;
        end
        MD_MTHI: m_hi = rs;
        MD_MTLO: m_lo = rs;
        default: ;
      endcase
      if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) len_q.push_back(m_left);
    end
  endtask

  // Drive one cycle (called #1 after a posedge), queue its expectations, step the model.
  task automatic apply(input logic rst_i, input md_op_t op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic dmd);
    exp_t e;
    reset       = rst_i;
    bus.md_op   = op;
    bus.rs_val  = rs;
    bus.rt_val  = rt;
    bus.d_is_md = dmd;
    e.en    = m_known;
    e.busy  = (m_left > 0);
    e.start = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    e.stall = dmd & (e.start | e.busy);
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.rdata = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'h0;
    exp_q.push_back(e);
    if (!rst_i && m_left > 0 && op != MD_NONE)
      $display("hazard: op %0d issued while busy at %0t, expecting it to be ignored", op, $time);
    @(posedge clk);
    model_edge(rst_i, op, rs, rt);
    #1;
  endtask

  task automatic idle(input int n, input logic dmd = 1'b0);
    for (int i = 0; i < n; i++) apply(1'b0, MD_NONE, $urandom, $urandom, dmd);
  endtask

  // Monitor: per-cycle output check plus busy run-length check.
  int run_len = 0;
  bit run_abort = 0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.en) begin
        chk("busy",     bus.busy,     e.busy);
        chk("start",    bus.start,    e.start);
        chk("stall_md", bus.stall_md, e.stall);
        chk("hi_o",     bus.hi_o,     e.hi);
        chk("lo_o",     bus.lo_o,     e.lo);
        chk("md_rdata", bus.md_rdata, e.rdata);
      end
    end
    if (bus.busy === 1'b1) begin
      run_len++;
      if (reset === 1'b1) run_abort = 1;
    end else if (run_len > 0) begin
      if (!run_abort) begin
        if (len_q.size() > 0) chk("busy_len", run_len, len_q.pop_front());
        else chk("busy_len_unexpected", run_len, 0);
      end
      run_len = 0;
      run_abort = 0;
    end
  end

  initial begin
    md_op_t op;
    logic [31:0] rt;
    int r;
    reset = 1'b1; bus.md_op = MD_NONE; bus.rs_val = '0; bus.rt_val = '0; bus.d_is_md = 1'b0;
    @(posedge clk); #1;
    apply(1'b1, MD_NONE, 0, 0, 0);
    apply(1'b1, MD_NONE, 0, 0, 0);
    idle(1);

    apply(1'b0, MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    idle(7);

    apply(1'b0, MD_DIVU, 32'd100, 32'd7, 0);
    idle(11);
    apply(1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    idle(11);

    apply(1'b0, MD_MTHI, 32'h11, 0, 0);
    apply(1'b0, MD_MTLO, 32'h22, 0, 0);
    apply(1'b0, MD_DIV, 32'd5, 32'd0, 0);
    idle(11);

    apply(1'b0, MD_MULT, 32'd1234, 32'hFFFF_F000, 1);
    idle(5, 1'b1);
    idle(1, 1'b1);
    apply(1'b0, MD_MFLO, 0, 0, 1);

    apply(1'b0, MD_DIV, 32'd50, 32'd3, 0);
    idle(2);
    apply(1'b1, MD_NONE, 0, 0, 0);
    idle(12);

    apply(1'b0, MD_MTHI, 32'hDEAD_BEEF, 0, 0);
    apply(1'b0, MD_MFHI, 0, 0, 0);

    apply(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(11);

    apply(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    apply(1'b0, MD_MTLO, 32'h5555_5555, 0, 0);
    apply(1'b0, MD_DIV, 32'd9, 32'd2, 1);
    idle(5);
    apply(1'b0, MD_MFHI, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        apply(1'b1, MD_NONE, 0, 0, 0);
      end else begin
        op = MD_NONE;
        if (m_left == 0 || r < 7) op = md_op_t'($urandom_range(0, 8));
        case ($urandom_range(0, 5))
          0:       rt = 32'h0;
          1:       rt = 32'hFFFF_FFFF;
          2:       rt = $urandom_range(1, 20);
          default: rt = $urandom;
        endcase
        apply(1'b0, op, ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom, rt,
              1'($urandom_range(0, 1)));
      end
    end

    idle(DC + 2);
    @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("len_q_drained", len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Execute-stage multiply/divide sequencing controller for the five-stage pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the E stage. It models the fixed multi-cycle latency of the multiply/divide resource with a busy counter and owns the HI/LO registers. It also raises the stall request the hazard unit uses to hold any D-stage multiply/divide instruction while the resource is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
md_op  input  4  E-stage operation code (package constants; MD_NONE = 0)
rs_val  input  32  E-stage forwarded rs operand
rt_val  input  32  E-stage forwarded rt operand
d_is_md  input  1  D-stage instruction is any multiply/divide-class op (incl. MF*/MT*)
start  output  1  combinational; md_op is MULT/MULTU/DIV/DIVU
busy  output  1  registered; operation in flight
stall_md  output  1  combinational; d_is_md & (start | busy)
hi_o  output  32  architectural HI register
lo_o  output  32  architectural LO register
md_rdata  output  32  combinational; hi_o when md_op = MFHI, lo_o when MFLO, else 0

Behaviour:
- Reset (reset=1 at posedge): hi_o=0, lo_o=0, busy=0, counter=0, pending HI/LO=0. An in-flight operation is discarded and HI/LO are not updated. Reset has priority over every other input.
- Accept rule: an op is accepted at a posedge when busy=0 and md_op is valid. When busy=1, md_op other than MD_NONE is a hazard-unit bug; the block ignores it and state is unchanged. The bench flags this case.
- MULT at accept: pending {HI,LO} = signed(rs_val) * signed(rt_val), giving a 64-bit product.
- MULTU at accept: the same computation, unsigned.
- DIV at accept: pending LO = signed quotient truncated toward zero; pending HI = remainder, which takes the sign of the dividend.
- DIVU at accept: the same computation, unsigned.
- Divide by zero (rt_val=0): the op still occupies DIV_CYCLES, but HI/LO stay unchanged at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Timing, with N = MULT_CYCLES or DIV_CYCLES:
  - On the accept edge, counter := N and busy := 1.
  - Each following edge decrements the counter.
  - On the edge where counter = 1, HI/LO := pending, busy := 0, counter := 0.
  - busy is therefore high for exactly N cycles, and new HI/LO are visible in the cycle after busy falls.
- MTHI/MTLO at accept: hi_o := rs_val or lo_o := rs_val on that edge, visible next cycle. busy is unaffected.
- MFHI/MFLO: a pure combinational read of the current registers. No state change.
- Back-to-back: a new op may be accepted on the same edge busy falls to 0 only if busy was already 0 before that edge. On the completion edge the op is held off by stall_md, because busy=1 during that cycle.
- The operands latch at accept. Changes to rs_val/rt_val afterwards do not affect the result.

Decomposition:
- Shared package mdu_defs:
  - MD_* op constants: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
  - default cycle-count constants
- Sub-module mdu_arith (combinational): takes op, rs, rt and produces pending_hi, pending_lo and div_by_zero.
- mdu_ctrl holds the counter, busy and the HI/LO registers.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3. Required: busy=1 for exactly 5 cycles, then hi_o=0xFFFFFFFF and lo_o=0xFFFFFFFA. hi_o/lo_o stay 0 while busy.
- DIVU rs=100, rt=7, then DIV rs=-7, rt=2 after completion. Required: first gives LO=14, HI=2 after 10 busy cycles; second gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=5, rt=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO. Required: busy for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- MULT accepted with d_is_md=1 on every cycle. Required: stall_md=1 on the start cycle and all 5 busy cycles, then 0 in the cycle after. An MFLO issued next returns the new LO on md_rdata.
- reset asserted on the 3rd busy cycle of a DIV. Required: next cycle busy=0, hi_o=0, lo_o=0, and no late writeback.
- MTHI rs=0xDEADBEEF, then MFHI in the following cycle. Required: md_rdata=0xDEADBEEF, busy stays 0 throughout.
